// File: rtl/music_playback_ctrl_pkg.sv
// Shared types and constants for the song-memory playback scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package music_playback_ctrl_pkg;

  // Note word width of the attached song memories.
  localparam int MEM_DATA_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_PLAY  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    LOOP_NONE = 2'b00,
    LOOP_ONE  = 2'b01,
    LOOP_ALL  = 2'b10,
    LOOP_RSVD = 2'b11
  } loop_t;

  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_STOP  = 3'd1,
    REQ_NEXT  = 3'd2,
    REQ_PREV  = 3'd3,
    REQ_PAUSE = 3'd4,
    REQ_PLAY  = 3'd5
  } req_t;

  // Collapse simultaneous requests to the single winner: stop > next > prev > pause > play.
  function automatic req_t prio_req(input logic stop, input logic next, input logic prev,
                                    input logic pause, input logic play);
    req_t r;
    if (stop)       r = REQ_STOP;
    else if (next)  r = REQ_NEXT;
    else if (prev)  r = REQ_PREV;
    else if (pause) r = REQ_PAUSE;
    else if (play)  r = REQ_PLAY;
    else            r = REQ_NONE;
    return r;
  endfunction

endpackage

// File: rtl/music_playback_ctrl_elapsed_timer.sv
// Elapsed-play timer: tick prescaler plus saturating 8-bit seconds counter.
// Latency: elapsed_sec updates on the edge that wraps the prescaler.
// Backpressure: none; en freezes the count, clr restarts it.
module music_playback_ctrl_elapsed_timer #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] elapsed_sec
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [TW-1:0] tick;

  // Count clk cycles while enabled; each prescaler wrap adds one second, stopping at 255.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tick        <= '0;
      elapsed_sec <= '0;
    end else if (en) begin
      if (tick == TW'(TICKS_PER_SEC - 1)) begin
        tick <= '0;
        if (elapsed_sec != 8'hFF) elapsed_sec <= elapsed_sec + 8'd1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/music_playback_ctrl.sv
// Playback scheduler: selects a song memory, sequences read_en/read_rst, muxes its notes out.
// Latency: play to first valid note is 3 cycles when the memory is already ready.
// Backpressure: none; single-cycle requests are acted on or dropped, all outputs registered.
module music_playback_ctrl
  import music_playback_ctrl_pkg::*;
#(
  parameter int NUM_SONGS     = 4,
  parameter int SEL_W         = 2,
  parameter int DATA_W        = MEM_DATA_WIDTH,
  parameter int ARM_TIMEOUT   = 16,
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        play,
  input  logic                        pause,
  input  logic                        stop,
  input  logic                        next,
  input  logic                        prev,
  input  logic [1:0]                  loop_mode,
  input  logic [NUM_SONGS-1:0]        mem_ready,
  input  logic [NUM_SONGS*DATA_W-1:0] mem_data,
  output logic [NUM_SONGS-1:0]        mem_read_en,
  output logic [NUM_SONGS-1:0]        mem_read_rst,
  output logic [SEL_W-1:0]            song_sel,
  output logic [DATA_W-1:0]           note_out,
  output logic                        note_valid,
  output logic [2:0]                  state_o,
  output logic                        song_done,
  output logic [7:0]                  elapsed_sec
);

  localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);

  state_t               state;
  req_t                 req;
  loop_t                loop;
  logic [ARM_W-1:0]     arm_cnt;
  logic [SEL_W-1:0]     sel_next;
  logic [SEL_W-1:0]     sel_prev;
  logic [NUM_SONGS-1:0] sel_onehot;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_ready;

  function automatic logic [NUM_SONGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SONGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Winning request, neighbour indices with wrap, and the selected memory's port.
  always_comb begin
    req        = prio_req(stop, next, prev, pause, play);
    loop       = loop_t'(loop_mode);
    sel_next   = (song_sel == SEL_W'(NUM_SONGS - 1)) ? '0 : song_sel + 1'b1;
    sel_prev   = (song_sel == '0) ? SEL_W'(NUM_SONGS - 1) : song_sel - 1'b1;
    sel_onehot = onehot(song_sel);
    sel_data   = mem_data[song_sel*DATA_W +: DATA_W];
    sel_ready  = mem_ready[song_sel];
  end

  // Playback FSM with registered memory handshakes and note stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      song_sel     <= '0;
      mem_read_en  <= '0;
      mem_read_rst <= '0;
      note_out     <= '0;
      note_valid   <= 1'b0;
      song_done    <= 1'b0;
      arm_cnt      <= '0;
    end else begin
      mem_read_rst <= '0;
      song_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_read_en <= '0;
          note_valid  <= 1'b0;
          case (req)
            REQ_NEXT: song_sel <= sel_next;
            REQ_PREV: song_sel <= sel_prev;
            REQ_PLAY: begin
              state        <= ST_START;
              mem_read_rst <= sel_onehot;
            end
            default: ;
          endcase
        end

        // Normally one cycle. After next/prev the first START cycle carries the
        // rewind of the old song, so a second cycle rewinds the newly selected one.
        ST_START: begin
          arm_cnt <= '0;
          if (mem_read_rst == sel_onehot) begin
            state       <= ST_ARM;
            mem_read_en <= sel_onehot;
          end else begin
            mem_read_rst <= sel_onehot;
          end
        end

        ST_ARM: begin
          if (req == REQ_STOP) begin
            state        <= ST_IDLE;
            mem_read_en  <= '0;
            mem_read_rst <= sel_onehot;
          end else if (sel_ready) begin
            state      <= ST_PLAY;
            note_out   <= sel_data;
            note_valid <= 1'b1;
          end else if (arm_cnt == ARM_W'(ARM_TIMEOUT - 1)) begin
            // Memory never came ready: treat the song as empty.
            state       <= ST_DONE;
            mem_read_en <= '0;
            song_done   <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end

        ST_PLAY, ST_PAUSE: begin
          case (req)
            REQ_STOP: begin
              state        <= ST_IDLE;
              mem_read_en  <= '0;
              mem_read_rst <= sel_onehot;
              note_valid   <= 1'b0;
            end
            REQ_NEXT, REQ_PREV: begin
              state        <= ST_START;
              song_sel     <= (req == REQ_NEXT) ? sel_next : sel_prev;
              mem_read_en  <= '0;
              mem_read_rst <= sel_onehot;
              note_valid   <= 1'b0;
            end
            REQ_PAUSE: begin
              if (state == ST_PLAY) begin
                state       <= ST_PAUSE;
                mem_read_en <= '0;
                note_valid  <= 1'b0;
              end
            end
            REQ_PLAY: begin
              if (state == ST_PAUSE) begin
                // Resume without rewinding: the memory kept its pointer.
                state       <= ST_PLAY;
                mem_read_en <= sel_onehot;
              end else begin
                note_out   <= sel_data;
                note_valid <= sel_ready;
                if (!sel_ready) begin
                  state       <= ST_DONE;
                  mem_read_en <= '0;
                  song_done   <= 1'b1;
                end
              end
            end
            default: begin
              if (state == ST_PLAY) begin
                note_out   <= sel_data;
                note_valid <= sel_ready;
                if (!sel_ready) begin
                  state       <= ST_DONE;
                  mem_read_en <= '0;
                  song_done   <= 1'b1;
                end
              end
            end
          endcase
        end

        ST_DONE: begin
          mem_read_en <= '0;
          note_valid  <= 1'b0;
          case (loop)
            LOOP_ONE: begin
              state        <= ST_START;
              mem_read_rst <= sel_onehot;
            end
            LOOP_ALL: begin
              state        <= ST_START;
              song_sel     <= sel_next;
              mem_read_rst <= onehot(sel_next);
            end
            default: state <= ST_IDLE;
          endcase
        end

        default: begin
          state       <= ST_IDLE;
          mem_read_en <= '0;
          note_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

  music_playback_ctrl_elapsed_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state == ST_START),
    .en         (state == ST_PLAY),
    .elapsed_sec(elapsed_sec)
  );

endmodule

// File: tb/tb_music_playback_ctrl.sv
// Self-checking bench for music_playback_ctrl with a note scoreboard.
// Latency: checks registered outputs 1 time unit after each active edge.
// Backpressure: n/a.
module tb_music_playback_ctrl;

  localparam int NS = 4;
  localparam int DW = 10;

  localparam logic [4:0] R_STOP  = 5'b10000;
  localparam logic [4:0] R_NEXT  = 5'b01000;
  localparam logic [4:0] R_PREV  = 5'b00100;
  localparam logic [4:0] R_PAUSE = 5'b00010;
  localparam logic [4:0] R_PLAY  = 5'b00001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             play, pause, stop, next, prev;
  logic [1:0]       loop_mode;
  logic [NS-1:0]    mem_ready;
  logic [NS*DW-1:0] mem_data;
  logic [NS-1:0]    mem_read_en;
  logic [NS-1:0]    mem_read_rst;
  logic [1:0]       song_sel;
  logic [DW-1:0]    note_out;
  logic             note_valid;
  logic [2:0]       state_o;
  logic             song_done;
  logic [7:0]       elapsed_sec;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  music_playback_ctrl #(
    .NUM_SONGS(NS), .SEL_W(2), .DATA_W(DW), .ARM_TIMEOUT(16), .TICKS_PER_SEC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop), .next(next),
    .prev(prev), .loop_mode(loop_mode), .mem_ready(mem_ready), .mem_data(mem_data),
    .mem_read_en(mem_read_en), .mem_read_rst(mem_read_rst), .song_sel(song_sel),
    .note_out(note_out), .note_valid(note_valid), .state_o(state_o),
    .song_done(song_done), .elapsed_sec(elapsed_sec)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid note must match the oldest note driven while the song was ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && note_valid === 1'b1) begin
      if (exp_q.size() == 0) check("note_unexpected", 32'(note_out), 32'hFFFF_FFFF);
      else check("note_out", 32'(note_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [4:0] r);
    {stop, next, prev, pause, play} = r;
    step(1);
    {stop, next, prev, pause, play} = '0;
  endtask

  task automatic drive_note(input int s);
    logic [DW-1:0] d;
    d = DW'($urandom_range(0, 1023));
    mem_data[s*DW +: DW] = d;
    exp_q.push_back(d);
    step(1);
  endtask

  // Memory s must already be ready; leaves the bench just after the first PLAY capture.
  task automatic start_song(input int s);
    exp_q.push_back(mem_data[s*DW +: DW]);
    request(R_PLAY);
    step(2);
  endtask

  initial begin
    rst_n = 1'b0;
    {stop, next, prev, pause, play} = '0;
    loop_mode = 2'b00;
    mem_ready = '0;
    mem_data  = {$urandom(), $urandom()};
    step(2);
    check("rst_state", 32'(state_o), 0);
    check("rst_sel", 32'(song_sel), 0);
    check("rst_en", 32'(mem_read_en), 0);
    check("rst_rst", 32'(mem_read_rst), 0);
    check("rst_note", 32'(note_out), 0);
    check("rst_valid", 32'(note_valid), 0);
    check("rst_done", 32'(song_done), 0);
    check("rst_elapsed", 32'(elapsed_sec), 0);
    rst_n = 1'b1;
    step(1);

    // Play song 0 with data 0x004 already present.
    mem_ready = 4'b0001;
    mem_data[0 +: DW] = 10'h004;
    exp_q.push_back(10'h004);
    request(R_PLAY);
    check("t1_start_state", 32'(state_o), 1);
    check("t1_start_rst", 32'(mem_read_rst), 4'b0001);
    check("t1_start_en", 32'(mem_read_en), 0);
    step(1);
    check("t1_arm_state", 32'(state_o), 2);
    check("t1_arm_en", 32'(mem_read_en), 4'b0001);
    check("t1_arm_rst", 32'(mem_read_rst), 0);
    step(1);
    check("t1_play_state", 32'(state_o), 3);
    check("t1_play_valid", 32'(note_valid), 1);
    check("t1_play_note", 32'(note_out), 10'h004);
    for (int i = 0; i < 8; i++) begin
      drive_note(0);
      check("t1_elapsed", 32'(elapsed_sec), 32'((i + 1) / 4));
    end

    // Pause: one more counted PLAY edge (tick=1), then frozen for 20 cycles.
    request(R_PAUSE);
    check("t3_pause_state", 32'(state_o), 4);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t3_pause_en", 32'(mem_read_en), 0);
      check("t3_pause_valid", 32'(note_valid), 0);
      check("t3_pause_elapsed", 32'(elapsed_sec), 2);
    end
    request(R_PLAY);
    check("t3_resume_state", 32'(state_o), 3);
    check("t3_resume_en", 32'(mem_read_en), 4'b0001);
    check("t3_resume_rst", 32'(mem_read_rst), 0);
    for (int i = 0; i < 3; i++) begin
      drive_note(0);
      check("t3_elapsed", 32'(elapsed_sec), (i == 2) ? 3 : 2);
    end

    // End of song, loop_mode 00.
    mem_ready = '0;
    step(1);
    check("t2_done_state", 32'(state_o), 5);
    check("t2_done_pulse", 32'(song_done), 1);
    check("t2_done_en", 32'(mem_read_en), 0);
    check("t2_done_valid", 32'(note_valid), 0);
    step(1);
    check("t2_idle_state", 32'(state_o), 0);
    check("t2_idle_en", 32'(mem_read_en), 0);
    check("t2_idle_done", 32'(song_done), 0);

    // End of song, loop_mode 10: advance to song 1 and restart it.
    mem_ready = 4'b0001;
    start_song(0);
    loop_mode = 2'b10;
    drive_note(0);
    drive_note(0);
    mem_ready = '0;
    step(1);
    check("t2b_done_pulse", 32'(song_done), 1);
    step(1);
    check("t2b_start_state", 32'(state_o), 1);
    check("t2b_sel", 32'(song_sel), 1);
    check("t2b_rst", 32'(mem_read_rst), 4'b0010);
    check("t2b_en", 32'(mem_read_en), 0);
    loop_mode = 2'b00;
    step(1);
    check("t2b_arm_state", 32'(state_o), 2);
    check("t2b_arm_en", 32'(mem_read_en), 4'b0010);
    request(R_STOP);
    check("t2b_stop_state", 32'(state_o), 0);
    check("t2b_stop_rst", 32'(mem_read_rst), 4'b0010);
    check("t2b_stop_en", 32'(mem_read_en), 0);
    step(1);
    check("t2b_stop_rst_end", 32'(mem_read_rst), 0);

    // Index wrap in IDLE.
    request(R_PREV);
    check("t4_sel0", 32'(song_sel), 0);
    request(R_PREV);
    check("t4_sel_wrap", 32'(song_sel), 3);
    check("t4_en", 32'(mem_read_en), 0);
    check("t4_rst", 32'(mem_read_rst), 0);
    request(R_NEXT);
    check("t4_sel_wrap_up", 32'(song_sel), 0);
    request(R_NEXT);
    check("t4_sel1", 32'(song_sel), 1);
    check("t4_en2", 32'(mem_read_en), 0);
    check("t4_rst2", 32'(mem_read_rst), 0);
    check("t4_state", 32'(state_o), 0);

    // Empty song 1: ARM times out after 16 cycles.
    request(R_PLAY);
    step(1);
    check("t5_arm_state", 32'(state_o), 2);
    step(15);
    check("t5_arm_last", 32'(state_o), 2);
    check("t5_no_done_yet", 32'(song_done), 0);
    step(1);
    check("t5_done_state", 32'(state_o), 5);
    check("t5_done_pulse", 32'(song_done), 1);
    step(1);
    check("t5_idle_state", 32'(state_o), 0);

    // Stop and next together during PLAY: stop wins.
    mem_ready = 4'b0010;
    start_song(1);
    drive_note(1);
    drive_note(1);
    request(R_STOP | R_NEXT);
    check("t6_state", 32'(state_o), 0);
    check("t6_sel", 32'(song_sel), 1);
    check("t6_rst", 32'(mem_read_rst), 4'b0010);
    check("t6_en", 32'(mem_read_en), 0);
    check("t6_valid", 32'(note_valid), 0);
    step(1);
    check("t6_rst_single", 32'(mem_read_rst), 0);

    // Next from PLAY: rewind old song, then the new one.
    start_song(1);
    request(R_NEXT);
    check("t7_state", 32'(state_o), 1);
    check("t7_sel", 32'(song_sel), 2);
    check("t7_rst_old", 32'(mem_read_rst), 4'b0010);
    check("t7_en", 32'(mem_read_en), 0);
    check("t7_valid", 32'(note_valid), 0);
    step(1);
    check("t7_rst_new", 32'(mem_read_rst), 4'b0100);
    step(1);
    check("t7_arm_state", 32'(state_o), 2);
    check("t7_arm_en", 32'(mem_read_en), 4'b0100);
    request(R_STOP);
    check("t7_stop_state", 32'(state_o), 0);
    request(R_PREV);
    request(R_PREV);
    check("t7_sel_back", 32'(song_sel), 0);

    // Long play: elapsed_sec must stop at 255.
    mem_ready = 4'b0001;
    start_song(0);
    check("t8_cleared", 32'(elapsed_sec), 0);
    for (int i = 0; i < 1030; i++) begin
      drive_note(0);
      check("t8_elapsed", 32'(elapsed_sec), ((i + 1) / 4 > 255) ? 255 : 32'((i + 1) / 4));
    end
    mem_ready = '0;
    step(2);
    check("t8_idle_state", 32'(state_o), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
